// File: rtl/coil_stage_ctrl.sv
// Single-stage coil firing sequencer: synchronised entry/exit sensors, delay, gated on-time, cooldown.
// Optional on-time ceiling (MAX_ON_CYC) enabled by defining COIL_WDOG_EN.
module coil_stage_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int COOLDOWN_CYC = 1000,
  parameter int MAX_ON_CYC   = 500000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [7:0]  I_creg,
  input  logic [23:0] I_dly,
  input  logic [23:0] I_lmt,
  input  logic        I_trig,
  input  logic        I_exit,
  output logic        O_coil,
  output logic [7:0]  O_eflg,
  output logic [23:0] O_acc
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_FIRE, S_COOLDOWN, S_FAULT
  } state_t;

  localparam int F_DONE    = 0;
  localparam int F_TIMEOUT = 1;
  localparam int F_ABORT   = 2;
  localparam int F_BADCFG  = 3;
  localparam int F_BUSY    = 4;
  localparam int F_WDOG    = 5;

  localparam logic [23:0] CD_LOAD = 24'(COOLDOWN_CYC);
  localparam logic [23:0] MAX_ON  = 24'(MAX_ON_CYC);
`ifdef COIL_WDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  state_t                 r_state;
  logic [23:0]            r_cnt;
  logic [23:0]            r_on_cnt;
  logic                   r_coil;
  logic [23:0]            r_acc;
  logic [5:0]             r_flags;
  logic [SYNC_STAGES-1:0] r_trig_sync;
  logic [SYNC_STAGES-1:0] r_exit_sync;
  logic                   r_trig_d;
  logic                   r_exit_d;
  logic                   r_sfire_d;

  logic       w_arm;
  logic       w_clr;
  logic       w_trig_evt;
  logic       w_exit_evt;
  logic       w_wdog_hit;
  logic       w_lmt_hit;
  logic       w_busy;
  logic [5:0] w_set;
  logic       w_creg_unused;

  assign w_arm         = I_creg[0];
  assign w_clr         = I_creg[2];
  assign w_creg_unused = ^I_creg[7:3];

  assign w_trig_evt = (r_trig_sync[SYNC_STAGES-1] & ~r_trig_d) | (I_creg[1] & ~r_sfire_d);
  assign w_exit_evt = r_exit_sync[SYNC_STAGES-1] & ~r_exit_d;
  assign w_lmt_hit  = (r_on_cnt == I_lmt);
  // Ceiling only bites when software asked for a longer on-time than the hard limit.
  assign w_wdog_hit = WDOG_ON && (r_on_cnt == MAX_ON) && (I_lmt > MAX_ON);
  assign w_busy     = (r_state == S_DELAY) || (r_state == S_FIRE) || (r_state == S_COOLDOWN);

  always_comb begin
    w_set = '0;
    case (r_state)
      S_ARMED: begin
        if (w_arm && w_trig_evt && (I_lmt == 24'd0)) w_set[F_BADCFG] = 1'b1;
      end
      S_DELAY: begin
        if (!w_arm) w_set[F_ABORT] = 1'b1;
        if (w_trig_evt) w_set[F_BUSY] = 1'b1;
      end
      S_FIRE: begin
        if (!w_arm) begin
          w_set[F_ABORT] = 1'b1;
        end else if (w_exit_evt) begin
          w_set[F_DONE] = 1'b1;
        end else if (w_lmt_hit) begin
          w_set[F_TIMEOUT] = 1'b1;
        end else if (w_wdog_hit) begin
          w_set[F_TIMEOUT] = 1'b1;
          w_set[F_WDOG]    = 1'b1;
        end
        if (w_trig_evt) w_set[F_BUSY] = 1'b1;
      end
      S_COOLDOWN: begin
        if (w_trig_evt) w_set[F_BUSY] = 1'b1;
      end
      default: w_set = '0;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_on_cnt    <= '0;
      r_coil      <= 1'b0;
      r_acc       <= '0;
      r_flags     <= '0;
      r_trig_sync <= '0;
      r_exit_sync <= '0;
      r_trig_d    <= 1'b0;
      r_exit_d    <= 1'b0;
      r_sfire_d   <= 1'b0;
    end else begin
      r_trig_sync <= {r_trig_sync[SYNC_STAGES-2:0], I_trig};
      r_exit_sync <= {r_exit_sync[SYNC_STAGES-2:0], I_exit};
      r_trig_d    <= r_trig_sync[SYNC_STAGES-1];
      r_exit_d    <= r_exit_sync[SYNC_STAGES-1];
      r_sfire_d   <= I_creg[1];
      r_flags     <= w_clr ? 6'd0 : (r_flags | w_set);

      case (r_state)
        S_IDLE: begin
          if (w_arm) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!w_arm) begin
            r_state <= S_IDLE;
          end else if (w_trig_evt) begin
            if (I_lmt == 24'd0) begin
              r_state <= S_FAULT;
            end else if (I_dly == 24'd0) begin
              r_state  <= S_FIRE;
              r_coil   <= 1'b1;
              r_on_cnt <= 24'd1;
            end else begin
              r_state <= S_DELAY;
              r_cnt   <= I_dly;
            end
          end
        end
        S_DELAY: begin
          if (!w_arm) begin
            r_state <= S_COOLDOWN;
            r_cnt   <= CD_LOAD;
          end else if (r_cnt == 24'd1) begin
            r_state  <= S_FIRE;
            r_coil   <= 1'b1;
            r_on_cnt <= 24'd1;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        S_FIRE: begin
          if (!w_arm || w_exit_evt || w_lmt_hit || w_wdog_hit) begin
            r_state <= S_COOLDOWN;
            r_coil  <= 1'b0;
            r_cnt   <= CD_LOAD;
            r_acc   <= r_on_cnt;
          end else if (r_on_cnt != 24'hFFFFFF) begin
            r_on_cnt <= r_on_cnt + 24'd1;
          end
        end
        S_COOLDOWN: begin
          if (r_cnt <= 24'd1) begin
            r_state <= w_arm ? S_ARMED : S_IDLE;
          end else begin
            r_cnt <= r_cnt - 24'd1;
          end
        end
        S_FAULT: begin
          if (!w_arm && w_clr) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_coil  <= 1'b0;
        end
      endcase
    end
  end

  assign O_coil = r_coil;
  assign O_acc  = r_acc;
  assign O_eflg = {w_busy, 1'b0, r_flags};

endmodule

// File: tb/tb_coil_stage_ctrl.sv
// Directed bench for coil_stage_ctrl; sensor events land 3 edges after the pin rises (2 sync + edge detect).
module tb_coil_stage_ctrl;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [7:0]  I_creg;
  logic [23:0] I_dly;
  logic [23:0] I_lmt;
  logic        I_trig;
  logic        I_exit;
  logic        O_coil;
  logic [7:0]  O_eflg;
  logic [23:0] O_acc;

  int checks = 0;
  int errors = 0;

  coil_stage_ctrl #(
    .SYNC_STAGES (2),
    .COOLDOWN_CYC(8),
    .MAX_ON_CYC  (20)
  ) dut (
    .I_clk  (I_clk),
    .I_rst_n(I_rst_n),
    .I_creg (I_creg),
    .I_dly  (I_dly),
    .I_lmt  (I_lmt),
    .I_trig (I_trig),
    .I_exit (I_exit),
    .O_coil (O_coil),
    .O_eflg (O_eflg),
    .O_acc  (O_acc)
  );

  always #5 I_clk = ~I_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge I_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    I_rst_n = 1'b0; I_creg = 8'h00; I_dly = '0; I_lmt = '0; I_trig = 1'b0; I_exit = 1'b0;
    step(2);
    chk("rst_coil", 32'(O_coil), 32'd0);
    chk("rst_eflg", 32'(O_eflg), 32'h00);
    chk("rst_acc",  32'(O_acc),  32'd0);
    I_rst_n = 1'b1;

    // 1: sensor trigger, dly=10, exit timed so the coil stays on 40 clocks
    I_creg = 8'h01; I_dly = 24'd10; I_lmt = 24'd100;
    step(1);
    I_trig = 1'b1;
    step(1);
    I_trig = 1'b0;
    step(11);
    chk("t1_coil_before", 32'(O_coil), 32'd0);
    chk("t1_busy_delay",  32'(O_eflg), 32'h80);
    step(1);
    chk("t1_coil_rise", 32'(O_coil), 32'd1);
    step(37);
    I_exit = 1'b1;
    step(2);
    chk("t1_coil_39", 32'(O_coil), 32'd1);
    step(1);
    I_exit = 1'b0;
    chk("t1_coil_fall", 32'(O_coil), 32'd0);
    chk("t1_acc",       32'(O_acc),  32'd40);
    chk("t1_eflg",      32'(O_eflg), 32'h81);
    step(7);
    chk("t1_cool_last", 32'(O_eflg), 32'h81);
    step(1);
    chk("t1_cool_done", 32'(O_eflg), 32'h01);
    I_creg = 8'h05;
    step(1);
    chk("t1_clear", 32'(O_eflg), 32'h00);

    // 2: soft fire, dly=0, lmt=5, no exit
    I_dly = 24'd0; I_lmt = 24'd5; I_creg = 8'h03;
    step(1);
    chk("t2_coil_rise", 32'(O_coil), 32'd1);
    I_creg = 8'h01;
    step(4);
    chk("t2_coil_5th", 32'(O_coil), 32'd1);
    step(1);
    chk("t2_coil_fall", 32'(O_coil), 32'd0);
    chk("t2_acc",       32'(O_acc),  32'd5);
    chk("t2_eflg",      32'(O_eflg), 32'h82);
    step(7);
    chk("t2_cool_last", 32'(O_eflg), 32'h82);
    step(1);
    chk("t2_cool_done", 32'(O_eflg), 32'h02);
    I_creg = 8'h05;
    step(1);
    I_creg = 8'h01;

    // 3: lmt=0 faults; FAULT holds until disarm+clear
    I_lmt = 24'd0; I_creg = 8'h03;
    step(1);
    chk("t3_badcfg", 32'(O_eflg), 32'h08);
    chk("t3_coil",   32'(O_coil), 32'd0);
    I_creg = 8'h01; I_lmt = 24'd4;
    step(1);
    I_creg = 8'h03;
    step(1);
    chk("t3_fault_hold_coil", 32'(O_coil), 32'd0);
    I_creg = 8'h05;
    step(1);
    chk("t3_armed_clear", 32'(O_eflg), 32'h00);
    I_creg = 8'h04;
    step(1);
    I_creg = 8'h01;
    step(1);
    I_creg = 8'h03;
    step(1);
    chk("t3_refire_coil", 32'(O_coil), 32'd1);

    // 4: busy trigger in FIRE, then abort on the cycle on_cnt reaches lmt=4
    I_creg = 8'h01;
    step(1);
    I_creg = 8'h03;
    step(1);
    I_creg = 8'h01;
    step(1);
    chk("t4_coil_3", 32'(O_coil), 32'd1);
    I_creg = 8'h00;
    step(1);
    chk("t4_coil_abort", 32'(O_coil), 32'd0);
    chk("t4_eflg",       32'(O_eflg), 32'h94);
    chk("t4_acc",        32'(O_acc),  32'd4);
    step(8);
    chk("t4_idle", 32'(O_eflg), 32'h14);

    // 5: reset mid-FIRE, then clear with DONE set
    I_creg = 8'h04;
    step(1);
    chk("t5_clear", 32'(O_eflg), 32'h00);
    I_creg = 8'h01; I_dly = 24'd0; I_lmt = 24'd3;
    step(1);
    I_creg = 8'h03;
    step(1);
    I_creg = 8'h01;
    step(3);
    chk("t5_acc3",  32'(O_acc),  32'd3);
    chk("t5_eflg3", 32'(O_eflg), 32'h82);
    step(8);
    I_lmt = 24'd100; I_creg = 8'h03;
    step(1);
    chk("t5_coil_on", 32'(O_coil), 32'd1);
    I_creg = 8'h01;
    step(2);
    I_rst_n = 1'b0;
    step(1);
    chk("t5_rst_coil", 32'(O_coil), 32'd0);
    chk("t5_rst_eflg", 32'(O_eflg), 32'h00);
    chk("t5_rst_acc",  32'(O_acc),  32'd0);
    I_rst_n = 1'b1; I_dly = 24'd2;
    step(1);
    I_creg = 8'h03;
    step(1);
    chk("t5_delay_1", 32'(O_coil), 32'd0);
    I_creg = 8'h01;
    step(1);
    chk("t5_delay_2", 32'(O_coil), 32'd0);
    step(1);
    chk("t5_fire", 32'(O_coil), 32'd1);
    I_exit = 1'b1;
    step(3);
    I_exit = 1'b0;
    chk("t5_done_coil", 32'(O_coil), 32'd0);
    chk("t5_done_acc",  32'(O_acc),  32'd3);
    chk("t5_done_eflg", 32'(O_eflg), 32'h81);
    I_creg = 8'h05;
    step(1);
    chk("t5_clr_sticky", 32'(O_eflg), 32'h80);
    I_creg = 8'h00;
    step(7);
    chk("t5_idle", 32'(O_eflg), 32'h00);

`ifdef COIL_WDOG_EN
    // 6: on-time ceiling of 20 below lmt=1000
    I_creg = 8'h01; I_dly = 24'd0; I_lmt = 24'd1000;
    step(1);
    I_creg = 8'h03;
    step(1);
    chk("t6_coil_rise", 32'(O_coil), 32'd1);
    I_creg = 8'h01;
    step(19);
    chk("t6_coil_20", 32'(O_coil), 32'd1);
    step(1);
    chk("t6_coil_fall", 32'(O_coil), 32'd0);
    chk("t6_acc",       32'(O_acc),  32'd20);
    chk("t6_eflg",      32'(O_eflg), 32'hA2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
